audio_mixer: RTL and testbench

- Upstream feeder for the 1-bit sigma-delta audio DAC.
- On each sample strobe it snapshots the AY channel levels and the ULA beeper/tape bits, then accumulates them sequentially with per-channel attenuation.
- Optionally removes DC with a leaky-integrator high-pass, then saturates.
- Emits an unsigned excess-2^MSBI sample that wires straight to the DAC's DACin, plus a one-cycle valid pulse.

---
 rtl/audio_mixer_if.sv | 40 ++++
 rtl/audio_mixer.sv | 185 ++++++++++++++++++
 tb/tb_audio_mixer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/audio_mixer_if.sv
// audio_mixer_if: sample-request / sample-result bundle between the mixer
// and its surroundings (AY/ULA sources upstream, sigma-delta DAC downstream).
//   CE            sample-rate strobe into the mixer
//   AY_A/B/C      AY channel levels, unsigned 8-bit
//   GAIN          per-channel attenuation shifts ([1:0]=A, [3:2]=B, [5:4]=C)
//   EAR, MIC      ULA beeper / tape bits
//   DC_EN         enable DC-blocking high-pass
//   SAMPLE        excess-2^MSBI result, feeds the DAC
//   SAMPLE_VALID  one-cycle pulse when SAMPLE updates
//   BUSY          mixer is computing a sample
//   CLIP          one-cycle pulse with SAMPLE_VALID when saturation occurred
//   OVERRUN       sticky: CE arrived while BUSY
// master = the side driving requests, slave = the mixer.
interface audio_mixer_if #(
  parameter int MSBI = 7
);
  logic            CE;
  logic [7:0]      AY_A;
  logic [7:0]      AY_B;
  logic [7:0]      AY_C;
  logic [5:0]      GAIN;
  logic            EAR;
  logic            MIC;
  logic            DC_EN;
  logic [MSBI:0]   SAMPLE;
  logic            SAMPLE_VALID;
  logic            BUSY;
  logic            CLIP;
  logic            OVERRUN;

  modport master (
    output CE, AY_A, AY_B, AY_C, GAIN, EAR, MIC, DC_EN,
    input  SAMPLE, SAMPLE_VALID, BUSY, CLIP, OVERRUN
  );

  modport slave (
    input  CE, AY_A, AY_B, AY_C, GAIN, EAR, MIC, DC_EN,
    output SAMPLE, SAMPLE_VALID, BUSY, CLIP, OVERRUN
  );
endinterface

// File: rtl/audio_mixer.sv
// audio_mixer: upstream feeder for the 1-bit sigma-delta audio DAC.
// On CE it snapshots the AY levels and ULA bits, accumulates them one term
// per clock with per-channel attenuation, optionally removes DC with a
// leaky-integrator high-pass, saturates and emits an excess-2^MSBI sample.
// Ports:
//   CLK    system clock
//   RESET  synchronous, active-high reset
//   bus    audio_mixer_if.slave (request inputs, sample outputs)
// Parameters:
//   MSBI   output sample MSB index (3..10)
//   DCK    DC-tracker time-constant shift
module audio_mixer #(
  parameter int MSBI = 7,
  parameter int DCK  = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  audio_mixer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ACC_A    = 3'd1,
    ACC_B    = 3'd2,
    ACC_C    = 3'd3,
    ACC_BEEP = 3'd4,
    POST     = 3'd5
  } state_t;

  localparam int DCW = 13 + DCK;
  // The centred mix spans about +-2^9; it is scaled so that range fills the
  // +-2^MSBI output range (right shift for narrow outputs, left for MSBI=10).
  localparam int SHR = (MSBI <= 9) ? (9 - MSBI) : 0;
  localparam int SHL = (MSBI > 9) ? (MSBI - 9) : 0;
  localparam logic signed [15:0] S_MAX = (16'sd1 <<< MSBI) - 16'sd1;
  localparam logic signed [15:0] S_MIN = -(16'sd1 <<< MSBI);
  localparam logic [MSBI:0] MIDSCALE = {1'b1, {MSBI{1'b0}}};

  state_t state;
  state_t state_next;

  logic [7:0]  snap_a;
  logic [7:0]  snap_b;
  logic [7:0]  snap_c;
  logic [5:0]  snap_gain;
  logic        snap_ear;
  logic        snap_mic;
  logic        snap_dc_en;

  logic [10:0] acc;
  logic [10:0] term;
  logic [10:0] acc_next;

  logic signed [DCW-1:0] dc_acc;
  logic signed [DCW-1:0] dc_acc_next;
  logic signed [12:0]    centered;
  logic signed [12:0]    dc;
  logic signed [13:0]    y;
  logic signed [15:0]    s_scaled;
  logic [MSBI:0]         sample_next;
  logic                  clip_next;

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state sequencing and the accumulator term added in each state.
  always_comb begin
    state_next = state;
    term       = 11'd0;
    case (state)
      IDLE: begin
        if (bus.CE) begin
          state_next = ACC_A;
        end else begin
          state_next = IDLE;
        end
      end
      ACC_A: begin
        term       = {3'b000, snap_a >> snap_gain[1:0]};
        state_next = ACC_B;
      end
      ACC_B: begin
        term       = {3'b000, snap_b >> snap_gain[3:2]};
        state_next = ACC_C;
      end
      ACC_C: begin
        term       = {3'b000, snap_c >> snap_gain[5:4]};
        state_next = ACC_BEEP;
      end
      ACC_BEEP: begin
        term       = (snap_ear ? 11'd256 : 11'd0) + (snap_mic ? 11'd32 : 11'd0);
        state_next = POST;
      end
      POST: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    acc_next = acc + term;
  end

  // Post-processing: centre, optional DC removal, scale and saturate.
  always_comb begin
    centered = $signed({2'b00, acc}) - 13'sd512;
    dc       = 13'(dc_acc >>> DCK);
    if (snap_dc_en) begin
      y           = 14'(centered) - 14'(dc);
      dc_acc_next = dc_acc + DCW'(y);
    end else begin
      y           = 14'(centered);
      dc_acc_next = '0;
    end
    // Arithmetic shift gives floor rounding for negative values.
    s_scaled = (16'(y) <<< SHL) >>> SHR;
    if (s_scaled > S_MAX) begin
      sample_next = '1;
      clip_next   = 1'b1;
    end else if (s_scaled < S_MIN) begin
      sample_next = '0;
      clip_next   = 1'b1;
    end else begin
      // Two's complement to excess-2^MSBI: invert the sign bit.
      sample_next = {~s_scaled[MSBI], s_scaled[MSBI-1:0]};
      clip_next   = 1'b0;
    end
  end

  // Snapshot, accumulator, DC tracker and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      snap_a           <= 8'd0;
      snap_b           <= 8'd0;
      snap_c           <= 8'd0;
      snap_gain        <= 6'd0;
      snap_ear         <= 1'b0;
      snap_mic         <= 1'b0;
      snap_dc_en       <= 1'b0;
      acc              <= 11'd0;
      dc_acc           <= '0;
      bus.SAMPLE       <= MIDSCALE;
      bus.SAMPLE_VALID <= 1'b0;
      bus.CLIP         <= 1'b0;
      bus.BUSY         <= 1'b0;
      bus.OVERRUN      <= 1'b0;
    end else begin
      bus.SAMPLE_VALID <= 1'b0;
      bus.CLIP         <= 1'b0;
      bus.BUSY         <= (state_next != IDLE);
      if (state == IDLE) begin
        if (bus.CE) begin
          snap_a     <= bus.AY_A;
          snap_b     <= bus.AY_B;
          snap_c     <= bus.AY_C;
          snap_gain  <= bus.GAIN;
          snap_ear   <= bus.EAR;
          snap_mic   <= bus.MIC;
          snap_dc_en <= bus.DC_EN;
          acc        <= 11'd0;
        end
      end else begin
        // A request while busy is dropped, only flagged.
        if (bus.CE) begin
          bus.OVERRUN <= 1'b1;
        end
        if (state == POST) begin
          bus.SAMPLE       <= sample_next;
          bus.SAMPLE_VALID <= 1'b1;
          bus.CLIP         <= clip_next;
          dc_acc           <= dc_acc_next;
        end else begin
          acc <= acc_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_mixer.sv
// Self-checking bench for audio_mixer (MSBI=7, DCK=8): a table of directed
// mix vectors with hand-computed results, plus hand-written sequences for
// snapshot isolation, DC removal, overrun and reset abort.
module tb_audio_mixer;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   dc_m   = 0;

  always #5 CLK = ~CLK;

  audio_mixer_if #(.MSBI(7)) bus ();

  audio_mixer #(.MSBI(7), .DCK(8)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [5:0] gain;
    logic       ear;
    logic       mic;
    logic [7:0] exp_sample;
    logic       exp_clip;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic set_inputs(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input logic [5:0] gain, input logic ear, input logic mic,
                            input logic dc_en);
    bus.AY_A  = a;
    bus.AY_B  = b;
    bus.AY_C  = c;
    bus.GAIN  = gain;
    bus.EAR   = ear;
    bus.MIC   = mic;
    bus.DC_EN = dc_en;
  endtask

  // Independent model of the DC-blocked path (DCK=8, output shift 2).
  task automatic model_dc(input int acc_v, output logic [7:0] smp);
    int c, d, yv, s;
    c    = acc_v - 512;
    d    = dc_m >>> 8;
    yv   = c - d;
    dc_m = dc_m + yv;
    s    = yv >>> 2;
    if (s > 127) s = 127;
    else if (s < -128) s = -128;
    smp = 8'(s + 128);
  endtask

  // Issue CE (sampled at edge 0), wait for the result, check it and the
  // cycle after. Called at a negedge; returns at a negedge with CE low.
  task automatic run_sample(input string name, input logic [7:0] exp_s,
                            input logic exp_clip, input bit mutate);
    int cyc;
    bit seen;
    bus.CE = 1'b1;
    tick();
    bus.CE = 1'b0;
    check({name, " busy"}, 32'(bus.BUSY), 32'd1);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      tick();
      cyc++;
      if (mutate && cyc == 2) begin
        set_inputs(8'd255, 8'd255, 8'd255, 6'h3f, 1'b1, 1'b1, 1'b1);
      end
      if (bus.SAMPLE_VALID === 1'b1) seen = 1'b1;
    end
    check({name, " latency"}, 32'(cyc), 32'd5);
    check({name, " sample"}, 32'(bus.SAMPLE), 32'(exp_s));
    check({name, " clip"}, 32'(bus.CLIP), 32'(exp_clip));
    check({name, " idle"}, 32'(bus.BUSY), 32'd0);
    tick();
    check({name, " valid pulse"}, 32'(bus.SAMPLE_VALID), 32'd0);
    check({name, " clip pulse"}, 32'(bus.CLIP), 32'd0);
    check({name, " hold"}, 32'(bus.SAMPLE), 32'(exp_s));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] exp_s;
    logic [7:0] prev;
    int         valids;

    bus.CE = 1'b0;
    set_inputs(8'd0, 8'd0, 8'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    RESET = 1'b1;
    repeat (3) tick();
    check("reset sample", 32'(bus.SAMPLE), 32'h80);
    check("reset valid", 32'(bus.SAMPLE_VALID), 32'd0);
    check("reset busy", 32'(bus.BUSY), 32'd0);
    check("reset clip", 32'(bus.CLIP), 32'd0);
    check("reset overrun", 32'(bus.OVERRUN), 32'd0);
    RESET = 1'b0;
    tick();

    // name, A, B, C, GAIN, EAR, MIC, SAMPLE, CLIP   (DC_EN=0)
    vecs[0]  = '{"zero",       8'd0,   8'd0,   8'd0,   6'b000000, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{"full",       8'd255, 8'd255, 8'd255, 6'b000000, 1'b1, 1'b1, 8'hFF, 1'b1};
    vecs[2]  = '{"a128",       8'd128, 8'd0,   8'd0,   6'b000000, 1'b0, 1'b0, 8'h20, 1'b0};
    vecs[3]  = '{"a128 g1",    8'd128, 8'd0,   8'd0,   6'b000001, 1'b0, 1'b0, 8'h10, 1'b0};
    vecs[4]  = '{"ear",        8'd0,   8'd0,   8'd0,   6'b000000, 1'b1, 1'b0, 8'h40, 1'b0};
    vecs[5]  = '{"mic",        8'd0,   8'd0,   8'd0,   6'b000000, 1'b0, 1'b1, 8'h08, 1'b0};
    vecs[6]  = '{"mid",        8'd255, 8'd255, 8'd2,   6'b000000, 1'b0, 1'b0, 8'h80, 1'b0};
    vecs[7]  = '{"max atten",  8'd255, 8'd255, 8'd255, 6'b111111, 1'b0, 1'b0, 8'h17, 1'b0};
    vecs[8]  = '{"top noclip", 8'd255, 8'd255, 8'd255, 6'b000000, 1'b1, 1'b0, 8'hFF, 1'b0};
    vecs[9]  = '{"mix g1",     8'd255, 8'd255, 8'd255, 6'b000001, 1'b1, 1'b1, 8'hE7, 1'b0};
    vecs[10] = '{"mix g012",   8'd200, 8'd100, 8'd50,  6'b100100, 1'b0, 1'b0, 8'h41, 1'b0};
    vecs[11] = '{"clip edge",  8'd255, 8'd255, 8'd226, 6'b000000, 1'b1, 1'b1, 8'hFF, 1'b1};
    vecs[12] = '{"b128 g1",    8'd0,   8'd128, 8'd0,   6'b000100, 1'b0, 1'b0, 8'h10, 1'b0};
    vecs[13] = '{"c128 g3",    8'd0,   8'd0,   8'd128, 6'b110000, 1'b0, 1'b0, 8'h04, 1'b0};

    for (int i = 0; i < 14; i++) begin
      set_inputs(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].gain, vecs[i].ear, vecs[i].mic, 1'b0);
      run_sample(vecs[i].name, vecs[i].exp_sample, vecs[i].exp_clip, 1'b0);
    end

    // Inputs scrambled after the snapshot must not reach the result.
    set_inputs(8'd128, 8'd0, 8'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    run_sample("snapshot", 8'h20, 1'b0, 1'b1);

    // DC blocker: a mix already at midscale stays there.
    dc_m = 0;
    set_inputs(8'd255, 8'd255, 8'd2, 6'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      model_dc(512, exp_s);
      run_sample("dc mid", 8'h80, 1'b0, 1'b0);
    end
    // Step to acc=640: first result 0xA0, then a monotonic decay.
    set_inputs(8'd255, 8'd255, 8'd130, 6'd0, 1'b0, 1'b0, 1'b1);
    model_dc(640, exp_s);
    run_sample("dc step", 8'hA0, 1'b0, 1'b0);
    prev = bus.SAMPLE;
    for (int i = 1; i < 40; i++) begin
      model_dc(640, exp_s);
      run_sample("dc decay", exp_s, 1'b0, 1'b0);
      check("dc monotonic", 32'(bus.SAMPLE <= prev), 32'd1);
      prev = bus.SAMPLE;
    end
    check("dc decayed", 32'(bus.SAMPLE < 8'hA0), 32'd1);

    // Overrun: CE at edges 0 and 3, then at edge 6 with new inputs.
    set_inputs(8'd128, 8'd0, 8'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    bus.CE = 1'b1;
    tick();
    valids = 0;
    for (int k = 1; k <= 12; k++) begin
      bus.CE = (k == 3 || k == 6) ? 1'b1 : 1'b0;
      if (k == 6) set_inputs(8'd0, 8'd0, 8'd0, 6'd0, 1'b0, 1'b0, 1'b0);
      tick();
      if (bus.SAMPLE_VALID === 1'b1) valids++;
      check($sformatf("overrun valid e%0d", k), 32'(bus.SAMPLE_VALID),
            32'((k == 5 || k == 11) ? 1 : 0));
      if (k == 3) check("overrun set", 32'(bus.OVERRUN), 32'd1);
      if (k == 5) check("overrun first", 32'(bus.SAMPLE), 32'h20);
      if (k == 11) check("overrun second", 32'(bus.SAMPLE), 32'h00);
    end
    bus.CE = 1'b0;
    check("overrun count", 32'(valids), 32'd2);
    check("overrun sticky", 32'(bus.OVERRUN), 32'd1);

    // Reset two edges into a computation aborts it.
    set_inputs(8'd255, 8'd255, 8'd255, 6'd0, 1'b1, 1'b1, 1'b0);
    bus.CE = 1'b1;
    tick();
    bus.CE = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      RESET = (k == 2) ? 1'b1 : 1'b0;
      tick();
      check($sformatf("abort valid e%0d", k), 32'(bus.SAMPLE_VALID), 32'd0);
      if (k == 2) begin
        check("abort sample", 32'(bus.SAMPLE), 32'h80);
        check("abort busy", 32'(bus.BUSY), 32'd0);
        check("abort overrun", 32'(bus.OVERRUN), 32'd0);
      end
    end
    RESET = 1'b0;
    set_inputs(8'd128, 8'd0, 8'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    run_sample("after abort", 8'h20, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
